sha_block_loader: RTL and testbench

//  Producer end of the SHA-256 message-schedule interface: accepts a stream of 32-bit words,

---
 rtl/sha_pkg.sv | 29 ++
 rtl/sha_block_loader.sv | 145 ++++++++++++++
 tb/tb_sha_block_loader.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/sha_pkg.sv
// ----------------------------------------------------------------------------
// sha_pkg
// Shared SHA-256 types and helpers used by the message-schedule producer.
//   Word            : one 32-bit message word
//   Block           : one 512-bit block, element k = k-th word of the block
//   HashState       : eight-word chaining value (not used by the loader)
//   WORDS_PER_BLOCK : words per SHA-256 block
//   bswap32()       : reverses byte order of a word
//   ld_phase_e      : loader phase decoded from the word counter
// ----------------------------------------------------------------------------
package sha_pkg;

  localparam int WORDS_PER_BLOCK = 16;

  typedef logic [31:0]                      Word;
  typedef logic [WORDS_PER_BLOCK-1:0][31:0] Block;
  typedef logic [7:0][31:0]                 HashState;

  // FILL: collecting words 0..14; LAST: the next accepted word completes the block.
  typedef enum logic [0:0] {
    PH_FILL = 1'b0,
    PH_LAST = 1'b1
  } ld_phase_e;

  function automatic Word bswap32(input Word w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/sha_block_loader.sv
// ----------------------------------------------------------------------------
// sha_block_loader
// Producer end of the SHA-256 message-schedule interface. Collects 32-bit
// words into a fill buffer; when the 16th word is accepted the whole block
// moves to the output register and is offered to the round pipeline with
// valid/newblock. The fill buffer keeps collecting while the output block
// waits, so only the 16th word of the next block can stall.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   in_valid_i   input word valid
//   in_ready_o   loader accepts a word this cycle
//   in_word_i    message word (big-endian unless byte swap enabled)
//   in_first_i   word is word 0 of a new message
//   blk_valid_o  W_o/newblock_o hold a complete block
//   blk_ready_i  pipeline head takes the block this cycle
//   W_o          block, W_o[k] = k-th word received
//   newblock_o   block is the first block of its message
//
// Configuration
//   SHA_LOADER_BYTESWAP_EN : when defined, in_word_i is little-endian and its
//                            bytes are reversed on capture.
// ----------------------------------------------------------------------------
module sha_block_loader
  import sha_pkg::*;
#(
  parameter int WORDS = 16,
  parameter int CNT_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [31:0]            in_word_i,
  input  logic                   in_first_i,
  output logic                   blk_valid_o,
  input  logic                   blk_ready_i,
  output logic [WORDS-1:0][31:0] W_o,
  output logic                   newblock_o
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS - 1);

  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   pending_q, pending_d;
  logic                   fill_first_q, fill_first_d;
  logic [WORDS-1:0][31:0] fill_q, fill_d;
  logic [WORDS-1:0][31:0] w_q, w_d;
  logic                   newblock_q, newblock_d;

  ld_phase_e              phase_s;
  Word                    cap_word_s;
  logic                   accept_s;

  // Word as it is stored: optionally byte-reversed on capture.
  always_comb begin
`ifdef SHA_LOADER_BYTESWAP_EN
    cap_word_s = bswap32(in_word_i);
`else
    cap_word_s = in_word_i;
`endif
  end

  // Phase decode from the word counter.
  always_comb begin
    if (cnt_q == LAST_IDX) begin
      phase_s = PH_LAST;
    end else begin
      phase_s = PH_FILL;
    end
  end

  // State register: counter, flags, fill buffer and output block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q        <= '0;
      pending_q    <= 1'b0;
      fill_first_q <= 1'b0;
      fill_q       <= '0;
      w_q          <= '0;
      newblock_q   <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      pending_q    <= pending_d;
      fill_first_q <= fill_first_d;
      fill_q       <= fill_d;
      w_q          <= w_d;
      newblock_q   <= newblock_d;
    end
  end

  // Next-state logic: word capture, abort on in_first, block completion and issue.
  always_comb begin
    cnt_d        = cnt_q;
    fill_first_d = fill_first_q;
    fill_d       = fill_q;
    w_d          = w_q;
    newblock_d   = newblock_q;
    accept_s     = in_valid_i && in_ready_o;

    // Issue frees the output register; a completion below may refill it.
    if (pending_q && blk_ready_i) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end

    if (accept_s) begin
      if (in_first_i && (cnt_q != '0)) begin
        // New message mid-block: drop the partial block, restart at word 0.
        fill_d[0]    = cap_word_s;
        cnt_d        = CNT_W'(1);
        fill_first_d = 1'b1;
      end else begin
        fill_d[cnt_q] = cap_word_s;
        if (cnt_q == '0) begin
          fill_first_d = in_first_i;
        end else begin
          fill_first_d = fill_first_q;
        end
        if (phase_s == PH_LAST) begin
          // Block complete: move it (including this word) to the output.
          w_d        = fill_d;
          newblock_d = fill_first_q;
          pending_d  = 1'b1;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Outputs: only the completing word stalls, and only while the output is held.
  always_comb begin
    in_ready_o  = !((phase_s == PH_LAST) && pending_q && !blk_ready_i);
    blk_valid_o = pending_q;
    W_o         = w_q;
    newblock_o  = newblock_q;
  end

endmodule

// File: tb/tb_sha_block_loader.sv
module tb_sha_block_loader;

  logic                clk;
  logic                rst;
  logic                in_valid_i;
  logic                in_ready_o;
  logic [31:0]         in_word_i;
  logic                in_first_i;
  logic                blk_valid_o;
  logic                blk_ready_i;
  logic [15:0][31:0]   W_o;
  logic                newblock_o;

  int total;
  int passed;
  int failed;
  int timeouts;

  sha_block_loader dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_word_i   (in_word_i),
    .in_first_i  (in_first_i),
    .blk_valid_o (blk_valid_o),
    .blk_ready_i (blk_ready_i),
    .W_o         (W_o),
    .newblock_o  (newblock_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected stored form of a word.
  function automatic logic [31:0] ew(input logic [31:0] w);
`ifdef SHA_LOADER_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  // Expected block of words base, base+1, ... base+15.
  function automatic logic [15:0][31:0] blk_of(input logic [31:0] base);
    logic [15:0][31:0] b;
    for (int k = 0; k < 16; k++) b[k] = ew(base + 32'(k));
    return b;
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Offer one word, wait (bounded) for ready, complete the transfer on the next edge.
  task automatic push(input logic [31:0] w, input logic f);
    int guard;
    in_valid_i = 1'b1;
    in_word_i  = w;
    in_first_i = f;
    #1;
    guard = 0;
    while (!in_ready_o && guard < 200) begin
      @(posedge clk);
      #2;
      guard++;
    end
    if (guard >= 200) timeouts++;
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    in_first_i = 1'b0;
  endtask

  logic [15:0][31:0] exp_b;

  initial begin
    total = 0; passed = 0; failed = 0; timeouts = 0;
    rst = 1'b0; in_valid_i = 1'b0; in_word_i = 32'h0; in_first_i = 1'b0; blk_ready_i = 1'b1;

    // Reset state
    repeat (2) tick;
    chk("rst_valid", 512'(blk_valid_o), 512'd0);
    chk("rst_newblock", 512'(newblock_o), 512'd0);
    chk("rst_W", W_o, 512'd0);
    rst = 1'b1;
    #1;
    chk("rst_ready", 512'(in_ready_o), 512'd1);
    tick;

    // 1: single block, W_o[k]=k, one-cycle pulse
    for (int k = 0; k < 15; k++) push(32'(k), (k == 0));
    chk("t1_not_yet", 512'(blk_valid_o), 512'd0);
    push(32'd15, 1'b0);
    chk("t1_valid", 512'(blk_valid_o), 512'd1);
    chk("t1_W", W_o, blk_of(32'h0));
    chk("t1_newblock", 512'(newblock_o), 512'd1);
    tick;
    chk("t1_pulse", 512'(blk_valid_o), 512'd0);

    // 2: back-to-back blocks with output held; 16th word of second block stalls
    blk_ready_i = 1'b0;
    for (int k = 0; k < 16; k++) push(32'h100 + 32'(k), (k == 0));
    chk("t2_a_valid", 512'(blk_valid_o), 512'd1);
    for (int k = 0; k < 15; k++) push(32'h200 + 32'(k), 1'b0);
    in_valid_i = 1'b1; in_word_i = 32'h20F; in_first_i = 1'b0;
    #1;
    chk("t2_stall", 512'(in_ready_o), 512'd0);
    repeat (5) tick;
    chk("t2_stall_hold", 512'(in_ready_o), 512'd0);
    chk("t2_a_stable", W_o, blk_of(32'h100));
    chk("t2_a_newblock", 512'(newblock_o), 512'd1);
    blk_ready_i = 1'b1;
    #1;
    chk("t2_unstall", 512'(in_ready_o), 512'd1);
    tick;
    in_valid_i = 1'b0;
    // 5: issue and completion on the same edge keep valid high, W_o switches
    chk("t2_b_valid", 512'(blk_valid_o), 512'd1);
    chk("t2_b_W", W_o, blk_of(32'h200));
    chk("t2_b_newblock", 512'(newblock_o), 512'd0);
    tick;
    chk("t2_b_drained", 512'(blk_valid_o), 512'd0);

    // 3: abort after 7 words
    for (int k = 0; k < 7; k++) push(32'h300 + 32'(k), (k == 0));
    push(32'hDEADBEEF, 1'b1);
    for (int k = 0; k < 15; k++) push(32'h400 + 32'(k), 1'b0);
    exp_b[0] = ew(32'hDEADBEEF);
    for (int k = 1; k < 16; k++) exp_b[k] = ew(32'h400 + 32'(k - 1));
    chk("t3_valid", 512'(blk_valid_o), 512'd1);
    chk("t3_W", W_o, exp_b);
    chk("t3_newblock", 512'(newblock_o), 512'd1);
    tick;

    // 4a: reset mid-block at word 9
    for (int k = 0; k < 9; k++) push(32'h500 + 32'(k), (k == 0));
    rst = 1'b0;
    #1;
    chk("t4_rst_valid", 512'(blk_valid_o), 512'd0);
    tick;
    rst = 1'b1;
    tick;
    for (int k = 0; k < 16; k++) push(32'h600 + 32'(k), 1'b0);
    chk("t4_after_valid", 512'(blk_valid_o), 512'd1);
    chk("t4_after_W", W_o, blk_of(32'h600));
    chk("t4_after_newblock", 512'(newblock_o), 512'd0);
    tick;

    // 4b: reset while a block is pending
    blk_ready_i = 1'b0;
    for (int k = 0; k < 16; k++) push(32'h700 + 32'(k), (k == 0));
    chk("t4_pending", 512'(blk_valid_o), 512'd1);
    rst = 1'b0;
    #1;
    chk("t4_pend_rst", 512'(blk_valid_o), 512'd0);
    tick;
    rst = 1'b1;
    repeat (2) tick;
    chk("t4_no_pulse", 512'(blk_valid_o), 512'd0);
    blk_ready_i = 1'b1;

    // 6: byte order of captured word
    push(32'h11223344, 1'b1);
    for (int k = 1; k < 16; k++) push(32'h800 + 32'(k), 1'b0);
`ifdef SHA_LOADER_BYTESWAP_EN
    chk("t6_w0", 512'(W_o[0]), 512'(32'h44332211));
`else
    chk("t6_w0", 512'(W_o[0]), 512'(32'h11223344));
`endif
    chk("t6_w15", 512'(W_o[15]), 512'(ew(32'h80F)));
    tick;

    chk("no_timeout", 512'(timeouts), 512'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
